// File: rtl/uart_th_pkg.sv
// Shared constants for the UART threshold bank: command/response bytes, FSM encoding,
// per-channel operation codes and the readback byte-count helper.
package uart_th_pkg;

    localparam logic [7:0] CMD_INC      = 8'h77;  // 'w'
    localparam logic [7:0] CMD_DEC      = 8'h73;  // 's'
    localparam logic [7:0] CMD_DEF      = 8'h7A;  // 'z'
    localparam logic [7:0] CMD_RD       = 8'h72;  // 'r'
    localparam logic [7:0] CMD_SEL_BASE = 8'h41;  // 'A'
    localparam logic [7:0] CMD_SEL_LAST = 8'h5A;  // 'Z'
    localparam logic [7:0] RSP_BAD      = 8'h3F;  // '?'
    localparam logic [7:0] RSP_LOCK     = 8'h58;  // 'X'

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_SEND   = 2'd2;
    localparam logic [1:0] ST_GAP    = 2'd3;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_INC,
        OP_DEC,
        OP_DEF
    } th_op_e;

    function automatic int unsigned nbytes(input int unsigned w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_th_bank_channel.sv
// th_channel: one threshold register with saturating step up/down and restore-to-default.
module th_channel
    import uart_th_pkg::*;
#(
    parameter int unsigned     TH_W   = 16,
    parameter bit              SIGNED = 1'b1,
    parameter logic [TH_W-1:0] MIN    = '0,
    parameter logic [TH_W-1:0] MAX    = TH_W'(255),
    parameter logic [TH_W-1:0] STEP   = TH_W'(1),
    parameter logic [TH_W-1:0] DEF    = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  th_op_e          op,
    output logic [TH_W-1:0] th,
    output logic            changed
);

    // Two guard bits: unsigned increments and decrements both stay in range, no wrap.
    localparam int unsigned XW = TH_W + 2;

    function automatic logic signed [XW-1:0] ext(input logic [TH_W-1:0] v);
        return SIGNED ? $signed({{2{v[TH_W-1]}}, v}) : $signed({2'b00, v});
    endfunction

    logic [TH_W-1:0]        th_q, th_d;
    logic signed [XW-1:0]   cur_x, step_x, sum_x, dif_x;

    always_comb begin
        cur_x  = ext(th_q);
        step_x = $signed({2'b00, STEP});
        sum_x  = cur_x + step_x;
        dif_x  = cur_x - step_x;
        th_d   = th_q;
        case (op)
            OP_INC:  th_d = (sum_x > ext(MAX)) ? MAX : sum_x[TH_W-1:0];
            OP_DEC:  th_d = (dif_x < ext(MIN)) ? MIN : dif_x[TH_W-1:0];
            OP_DEF:  th_d = DEF;
            default: th_d = th_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            th_q <= DEF;
        end else begin
            th_q <= th_d;
        end
    end

    assign th      = th_q;
    assign changed = (th_d != th_q);

endmodule

// File: rtl/uart_th_bank.sv
// uart_th_bank: command decoder, channel select and transmit FSM over NUM_CH th_channel regs.
// Optional build macro UART_TH_BANK_LOCK_EN adds cfg_lock, which blocks 'w'/'s'/'z' writes.
module uart_th_bank
    import uart_th_pkg::*;
#(
    parameter int unsigned               NUM_CH   = 7,
    parameter int unsigned               TH_W     = 16,
    parameter bit                        SIGNED   = 1'b1,
    parameter logic [NUM_CH*TH_W-1:0]    MIN_VEC  = '0,
    parameter logic [NUM_CH*TH_W-1:0]    MAX_VEC  = {NUM_CH{TH_W'(255)}},
    parameter logic [NUM_CH*TH_W-1:0]    STEP_VEC = {NUM_CH{TH_W'(1)}},
    parameter logic [NUM_CH*TH_W-1:0]    DEF_VEC  = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef UART_TH_BANK_LOCK_EN
    input  logic                     cfg_lock,
`endif
    input  logic [7:0]               rx_data,
    input  logic                     rx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    output logic [NUM_CH*TH_W-1:0]   th_flat,
    output logic [4:0]               sel_ch,
    output logic                     th_changed,
    output logic                     rx_drop
);

    localparam int unsigned NB = nbytes(TH_W);
    localparam int unsigned XB = NB * 8;

    logic [1:0]        state_q, state_d;
    logic [7:0]        rsp_q, rsp_d;
    th_op_e            op_q, op_d;
    logic [4:0]        sel_q, sel_d, sel_new_q, sel_new_d;
    logic              sel_we_q, sel_we_d;
    logic [2:0]        total_q, total_d, idx_q, idx_d;
    logic              th_changed_q, rx_drop_q;
    logic              lock;
    logic [7:0]        sel_off;
    logic [NUM_CH-1:0] ch_changed;
    logic [TH_W-1:0]   cur_th;
    logic [XB-1:0]     ext_val, shifted;
    logic [7:0]        tx_byte;

`ifdef UART_TH_BANK_LOCK_EN
    assign lock = cfg_lock;
`else
    assign lock = 1'b0;
`endif

    assign sel_off = rx_data - CMD_SEL_BASE;

    always_comb begin
        state_d   = state_q;
        rsp_d     = rsp_q;
        op_d      = op_q;
        sel_d     = sel_q;
        sel_new_d = sel_new_q;
        sel_we_d  = sel_we_q;
        total_d   = total_q;
        idx_d     = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    op_d      = OP_NONE;
                    sel_we_d  = 1'b0;
                    sel_new_d = sel_off[4:0];
                    rsp_d     = rx_data;
                    idx_d     = '0;
                    total_d   = 3'(NB + 1);
                    state_d   = ST_UPDATE;
                    if (rx_data >= CMD_SEL_BASE && rx_data <= CMD_SEL_LAST) begin
                        total_d = 3'd1;
                        if (sel_off < 8'(NUM_CH)) begin
                            sel_we_d = 1'b1;
                        end else begin
                            rsp_d = RSP_BAD;
                        end
                    end else if (rx_data == CMD_INC || rx_data == CMD_DEC
                                 || rx_data == CMD_DEF) begin
                        if (lock) begin
                            rsp_d = RSP_LOCK;
                        end else if (rx_data == CMD_INC) begin
                            op_d = OP_INC;
                        end else if (rx_data == CMD_DEC) begin
                            op_d = OP_DEC;
                        end else begin
                            op_d = OP_DEF;
                        end
                    end else if (rx_data != CMD_RD) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_UPDATE: begin
                if (sel_we_q) begin
                    sel_d = sel_new_q;
                end
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = ST_GAP;
                end
            end
            default: begin
                state_d = (idx_q == total_q) ? ST_IDLE : ST_SEND;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rsp_q        <= '0;
            op_q         <= OP_NONE;
            sel_q        <= '0;
            sel_new_q    <= '0;
            sel_we_q     <= 1'b0;
            total_q      <= '0;
            idx_q        <= '0;
            th_changed_q <= 1'b0;
            rx_drop_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_q        <= rsp_d;
            op_q         <= op_d;
            sel_q        <= sel_d;
            sel_new_q    <= sel_new_d;
            sel_we_q     <= sel_we_d;
            total_q      <= total_d;
            idx_q        <= idx_d;
            th_changed_q <= |ch_changed;
            rx_drop_q    <= rx_valid && (state_q != ST_IDLE);
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        th_op_e ch_op;
        assign ch_op = (state_q == ST_UPDATE && sel_q == 5'(k)) ? op_q : OP_NONE;
        th_channel #(
            .TH_W   (TH_W),
            .SIGNED (SIGNED),
            .MIN    (MIN_VEC[k*TH_W +: TH_W]),
            .MAX    (MAX_VEC[k*TH_W +: TH_W]),
            .STEP   (STEP_VEC[k*TH_W +: TH_W]),
            .DEF    (DEF_VEC[k*TH_W +: TH_W])
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .op      (ch_op),
            .th      (th_flat[k*TH_W +: TH_W]),
            .changed (ch_changed[k])
        );
    end

    // Readback byte i (idx 1..NB) is the sign/zero-extended value, LSByte first.
    always_comb begin
        cur_th = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_q == 5'(k)) begin
                cur_th = th_flat[k*TH_W +: TH_W];
            end
        end
        ext_val = SIGNED ? XB'($signed(cur_th)) : XB'(cur_th);
        shifted = ext_val >> {idx_q - 3'd1, 3'b000};
        tx_byte = (idx_q == 3'd0) ? rsp_q : shifted[7:0];
    end

    assign tx_start   = (state_q == ST_SEND) && tx_ready;
    assign tx_data    = (state_q == ST_SEND) ? tx_byte : 8'h00;
    assign sel_ch     = sel_q;
    assign th_changed = th_changed_q;
    assign rx_drop    = rx_drop_q;

endmodule
